gray_input_sync: RTL and testbench

- Upstream conditioning stage for the Gray-to-binary decoder.
- Samples an asynchronous Gray-coded position bus (rotary/absolute encoder) into the clk domain and filters glitches and bounce.
- Presents only stable Gray words on gray_out, which feeds the decoder's gray input directly.
- Flags any accepted transition that changes more than one bit as a step error.

---
 rtl/gray_pkg.sv | 16 +
 rtl/gray_sync_chain.sv | 31 +++
 rtl/gray_input_sync.sv | 131 +++++++++++++
 tb/tb_gray_input_sync.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray input conditioning stage.
package gray_pkg;

    localparam int unsigned GRAY_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        SETTLE,
        TRACK,
        FILTER
    } state_t;

    function automatic logic is_single_step(input logic [31:0] a, input logic [31:0] b);
        return $countones(a ^ b) == 1;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Per-bit flop synchroniser, WIDTH bits wide and STAGES flops deep, reset to zero.
module gray_sync_chain
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH  = GRAY_W_DEFAULT,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_input_sync.sv
// Synchronises and debounces an asynchronous Gray bus; flags multi-bit steps.
// Optional saturating step-error counter enabled by GRAY_SYNC_ERR_CNT_EN.
module gray_input_sync
    import gray_pkg::*;
#(
    parameter int unsigned GRAY_W        = GRAY_W_DEFAULT,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GRAY_W-1:0] gray_in,
    output logic [GRAY_W-1:0] gray_out,
    output logic              gray_valid,
    output logic              step_err
`ifdef GRAY_SYNC_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [7:0]        err_count
`endif
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

    logic [GRAY_W-1:0] s;
    logic [GRAY_W-1:0] candidate;
    logic [CNT_W-1:0]  cnt;
    logic [FILL_W-1:0] fill;
    state_t            state;

    logic cnt_hit;
    logic settle_hit;

    gray_sync_chain #(
        .WIDTH  (GRAY_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (s)
    );

    assign cnt_hit    = (cnt + CNT_ONE) == CNT_MAX;
    assign settle_hit = (s == candidate) ? cnt_hit : (STABLE_CYCLES == 1);

    // SETTLE waits for the chain to flush: its reset zeros are not samples of gray_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SETTLE;
            fill       <= '0;
            candidate  <= '0;
            cnt        <= '0;
            gray_out   <= '0;
            gray_valid <= 1'b0;
            step_err   <= 1'b0;
        end else begin
            gray_valid <= 1'b0;
            step_err   <= 1'b0;
            unique case (state)
                SETTLE: begin
                    if (fill != FILL_MAX) begin
                        fill <= fill + FILL_ONE;
                    end else if (settle_hit) begin
                        candidate  <= s;
                        gray_out   <= s;
                        gray_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= TRACK;
                    end else if (s == candidate) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        candidate <= s;
                        cnt       <= CNT_ONE;
                    end
                end
                TRACK: begin
                    if (s != gray_out) begin
                        if (STABLE_CYCLES == 1) begin
                            candidate  <= s;
                            gray_out   <= s;
                            gray_valid <= 1'b1;
                            step_err   <= !is_single_step(32'(s), 32'(gray_out));
                        end else begin
                            candidate <= s;
                            cnt       <= CNT_ONE;
                            state     <= FILTER;
                        end
                    end
                end
                FILTER: begin
                    if (s == gray_out) begin
                        cnt   <= '0;
                        state <= TRACK;
                    end else if (s != candidate) begin
                        candidate <= s;
                        cnt       <= CNT_ONE;
                    end else if (cnt_hit) begin
                        gray_out   <= candidate;
                        gray_valid <= 1'b1;
                        step_err   <= !is_single_step(32'(candidate), 32'(gray_out));
                        cnt        <= '0;
                        state      <= TRACK;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= SETTLE;
                end
            endcase
        end
    end

`ifdef GRAY_SYNC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count <= '0;
        end else if (step_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_input_sync.sv
// Randomised, self-checking bench for gray_input_sync against a sample-history model.
module tb_gray_input_sync;

    localparam int W      = 4;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int LAT    = SYNC + STABLE;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] gray_out;
    logic         gray_valid;
    logic         step_err;
`ifdef GRAY_SYNC_ERR_CNT_EN
    logic         err_clr = 1'b0;
    logic [7:0]   err_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_input_sync #(
        .GRAY_W        (W),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .step_err   (step_err)
`ifdef GRAY_SYNC_ERR_CNT_EN
        ,
        .err_clr    (err_clr),
        .err_count  (err_count)
`endif
    );

    // Model: a word is accepted once the STABLE most recent real synchronised samples
    // agree and differ from the current output (or nothing has been accepted yet).
    logic [W-1:0] hist [$];
    logic [W-1:0] m_out   = '0;
    logic         m_valid = 1'b0;
    logic         m_step  = 1'b0;
    logic         m_acq   = 1'b0;
    int           m_errcnt = 0;

    task automatic step(input logic [W-1:0] v, input logic r, input logic c);
        int n;
        logic agree;
        logic [W-1:0] w;
        gray_in = v;
        rst = r;
`ifdef GRAY_SYNC_ERR_CNT_EN
        err_clr = c;
`endif
        @(posedge clk);
        if (r) begin
            hist.delete();
            m_out = '0; m_valid = 1'b0; m_step = 1'b0; m_acq = 1'b0; m_errcnt = 0;
        end else begin
            if (c) m_errcnt = 0;
            else if (m_step && m_errcnt < 255) m_errcnt++;
            hist.push_back(v);
            m_valid = 1'b0;
            m_step  = 1'b0;
            n = hist.size() - SYNC;
            if (n >= STABLE) begin
                w = hist[n-1];
                agree = 1'b1;
                for (int i = n - STABLE; i < n; i++) if (hist[i] != w) agree = 1'b0;
                if (agree && (!m_acq || w != m_out)) begin
                    m_step  = m_acq && ($countones(w ^ m_out) != 1);
                    m_out   = w;
                    m_valid = 1'b1;
                    m_acq   = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(W'($urandom_range(0, 15)), 1'b1, 1'b0);
            checks++;
            if (gray_out !== '0 || gray_valid !== 1'b0 || step_err !== 1'b0) begin
                failures++;
                $display("FAIL reset: out=%h valid=%b err=%b, required out=0 valid=0 err=0",
                         gray_out, gray_valid, step_err);
            end
        end
    endtask

    task automatic test_settle();
        int first = 0;
        int pulses = 0;
        for (int e = 1; e <= 10; e++) begin
            step(4'b0000, 1'b0, 1'b0);
            if (gray_valid === 1'b1) begin
                pulses++;
                if (first == 0) first = e;
            end
            checks++;
            if (gray_out !== m_out || gray_valid !== m_valid || step_err !== m_step) begin
                failures++;
                $display("FAIL settle e%0d: out=%h valid=%b err=%b, required out=%h valid=%b err=%b",
                         e, gray_out, gray_valid, step_err, m_out, m_valid, m_step);
            end
        end
        checks++;
        if (first != LAT || pulses != 1) begin
            failures++;
            $display("FAIL settle_latency: edge=%0d pulses=%0d, required edge=%0d pulses=1",
                     first, pulses, LAT);
        end
    endtask

    task automatic test_legal_step();
        int first = 0;
        for (int e = 1; e <= 10; e++) begin
            step(4'b0001, 1'b0, 1'b0);
            if (gray_valid === 1'b1 && first == 0) first = e;
            checks++;
            if (gray_out !== m_out || gray_valid !== m_valid || step_err !== m_step) begin
                failures++;
                $display("FAIL legal_step e%0d: out=%h valid=%b err=%b, required out=%h valid=%b err=%b",
                         e, gray_out, gray_valid, step_err, m_out, m_valid, m_step);
            end
        end
        checks++;
        if (first != LAT || gray_out !== 4'b0001) begin
            failures++;
            $display("FAIL legal_step_latency: edge=%0d out=%h, required edge=%0d out=1",
                     first, gray_out, LAT);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int e = 1; e <= 11; e++) begin
            step((e <= 3) ? 4'b0011 : 4'b0001, 1'b0, 1'b0);
            if (gray_valid === 1'b1) pulses++;
            checks++;
            if (gray_out !== 4'b0001 || gray_valid !== m_valid || gray_out !== m_out) begin
                failures++;
                $display("FAIL glitch e%0d: out=%h valid=%b, required out=1 valid=%b",
                         e, gray_out, gray_valid, m_valid);
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch_pulses: got %0d, required 0", pulses);
        end
    endtask

    task automatic test_bounce();
        int first = 0;
        logic err_seen = 1'b0;
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            step(4'b0010, 1'b0, 1'b0);
            if (gray_valid === 1'b1 && first == 0) begin
                first = e;
                err_seen = step_err;
            end
            checks++;
            if (gray_out !== m_out || gray_valid !== m_valid || step_err !== m_step) begin
                failures++;
                $display("FAIL bounce e%0d: out=%h valid=%b err=%b, required out=%h valid=%b err=%b",
                         e, gray_out, gray_valid, step_err, m_out, m_valid, m_step);
            end
        end
        checks++;
        if (first != LAT || err_seen !== 1'b1 || gray_out !== 4'b0010) begin
            failures++;
            $display("FAIL bounce_accept: edge=%0d err=%b out=%h, required edge=%0d err=1 out=2",
                     first, err_seen, gray_out, LAT);
        end
`ifdef GRAY_SYNC_ERR_CNT_EN
        checks++;
        if (err_count !== 8'd1) begin
            failures++;
            $display("FAIL bounce_err_count: got %0d, required 1", err_count);
        end
`endif
    endtask

    task automatic test_illegal_clear();
        int first = 0;
        logic both = 1'b0;
        step(4'b0000, 1'b1, 1'b0);
        for (int e = 0; e < 8; e++) step(4'b0000, 1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            step(4'b0110, 1'b0, 1'b0);
            if (gray_valid === 1'b1 && first == 0) begin
                first = e;
                both = step_err;
            end
            checks++;
            if (gray_out !== m_out || gray_valid !== m_valid || step_err !== m_step) begin
                failures++;
                $display("FAIL illegal e%0d: out=%h valid=%b err=%b, required out=%h valid=%b err=%b",
                         e, gray_out, gray_valid, step_err, m_out, m_valid, m_step);
            end
        end
        checks++;
        if (first != LAT || both !== 1'b1 || gray_out !== 4'b0110) begin
            failures++;
            $display("FAIL illegal_accept: edge=%0d err=%b out=%h, required edge=%0d err=1 out=6",
                     first, both, gray_out, LAT);
        end
`ifdef GRAY_SYNC_ERR_CNT_EN
        checks++;
        if (err_count !== 8'd1) begin
            failures++;
            $display("FAIL illegal_err_count: got %0d, required 1", err_count);
        end
        step(4'b0110, 1'b0, 1'b1);
        step(4'b0110, 1'b0, 1'b0);
        checks++;
        if (err_count !== 8'd0) begin
            failures++;
            $display("FAIL err_clr: got %0d, required 0", err_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int first = 0;
        for (int e = 1; e <= 3; e++) step(4'b0111, 1'b0, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        checks++;
        if (gray_out !== '0 || gray_valid !== 1'b0 || step_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: out=%h valid=%b err=%b, required out=0 valid=0 err=0",
                     gray_out, gray_valid, step_err);
        end
        for (int e = 1; e <= 9; e++) begin
            step(4'b0111, 1'b0, 1'b0);
            if (gray_valid === 1'b1 && first == 0) first = e;
            checks++;
            if (gray_out !== m_out || gray_valid !== m_valid || step_err !== m_step) begin
                failures++;
                $display("FAIL reacquire e%0d: out=%h valid=%b err=%b, required out=%h valid=%b err=%b",
                         e, gray_out, gray_valid, step_err, m_out, m_valid, m_step);
            end
        end
        checks++;
        if (first != LAT || gray_out !== 4'b0111) begin
            failures++;
            $display("FAIL reacquire_latency: edge=%0d out=%h, required edge=%0d out=7",
                     first, gray_out, LAT);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] cur;
        logic [W-1:0] v;
        logic         c;
        int           len;
        cur = m_out;
        for (int blk = 0; blk < 150; blk++) begin
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 1) == 1) v = cur ^ (W'(1) << $urandom_range(0, W - 1));
            else v = W'($urandom_range(0, 15));
            cur = v;
            for (int k = 0; k < len; k++) begin
                c = ($urandom_range(0, 19) == 0);
                step(v, 1'b0, c);
                checks++;
                if (gray_out !== m_out || gray_valid !== m_valid || step_err !== m_step) begin
                    failures++;
                    $display("FAIL random b%0d: out=%h valid=%b err=%b, required out=%h valid=%b err=%b",
                             blk, gray_out, gray_valid, step_err, m_out, m_valid, m_step);
                end
`ifdef GRAY_SYNC_ERR_CNT_EN
                checks++;
                if (err_count !== 8'(m_errcnt)) begin
                    failures++;
                    $display("FAIL random_err_count b%0d: got %0d, required %0d",
                             blk, err_count, m_errcnt);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_legal_step();
        test_glitch();
        test_bounce();
        test_illegal_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
